mrv1_rf_mp: RTL and testbench
=============================

MRV1_RF_MP -- requirements
Module: mrv1_rf_mp

Interface
REQ-001 Param DATA_WIDTH_P, default 32, register data width.
REQ-002 Param NUM_THREADS_P, default 8, hardware thread count, power of two.
REQ-003 Param RF_ADDR_WIDTH_P, default 5, per-thread register index width.
REQ-004 Param NUM_RD_PORTS_P, default 3, read port count (1..4).
REQ-005 Param NUM_WR_PORTS_P, default 2, write port count (1..2).
REQ-006 Param BYPASS_EN_P, default 1, same-cycle write-to-read forwarding enable.
REQ-007 Derived: TID_WIDTH_LP = $clog2(NUM_THREADS_P); ENTRIES_LP = NUM_THREADS_P << RF_ADDR_WIDTH_P.
REQ-008 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-009 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-010 rs_tid_i  in  [NUM_RD_PORTS_P][TID_WIDTH_LP]  per-read-port thread id.
REQ-011 rs_addr_i  in  [NUM_RD_PORTS_P][RF_ADDR_WIDTH_P]  per-read-port register index.
REQ-012 rs_data_o  out  [NUM_RD_PORTS_P][DATA_WIDTH_P]  read data, combinational.
REQ-013 wr_en_i / wr_tid_i / wr_addr_i / wr_data_i  in  [NUM_WR_PORTS_P] x 1 / TID / RF_ADDR / DATA  write ports.
REQ-014 clr_req_i  in  1  request zeroing of one thread's registers; clr_tid_i  in  TID_WIDTH_LP  target thread.
REQ-015 ready_o  out  1  array initialised, accepting writes and clear requests.
REQ-016 clr_busy_o  out  1  per-thread clear in progress; clr_done_o  out  1  one-cycle clear-complete pulse.
REQ-017 wr_conflict_o  out  1  registered flag: two write ports hit same entry previous cycle.

Function
REQ-018 Entry address SHALL be {tid, reg index}; reg index 0 SHALL read as 0 for any tid and writes to it SHALL be discarded.
REQ-019 FSM states INIT, IDLE, CLEAR, DONE; after reset SHALL be INIT.
REQ-020 INIT SHALL zero one entry per cycle, index 0..ENTRIES_LP-1 via sweep counter, then enter IDLE; ready_o SHALL rise the cycle IDLE is entered (ENTRIES_LP cycles after reset release).
REQ-021 While ready_o low, functional writes SHALL be ignored, reads SHALL return 0, clr_req_i SHALL be ignored.
REQ-022 In IDLE, clr_req_i high SHALL latch clr_tid_i and enter CLEAR next cycle; clr_req_i in any other state SHALL be ignored.
REQ-023 CLEAR SHALL zero entries {tid, 0..2^RF_ADDR_WIDTH_P-1}, one per cycle, clr_busy_o high throughout, then DONE for one cycle (clr_done_o high), then IDLE.
REQ-024 During CLEAR, writes and reads targeting the latched tid SHALL be dropped / return 0; other threads SHALL operate normally.
REQ-025 Writes SHALL take effect at the next rising edge; multiple ports to same entry: highest port index wins.
REQ-026 Same-entry multi-write (reg index != 0, all enabled) SHALL set wr_conflict_o for exactly the following cycle.
REQ-027 BYPASS_EN_P=1: read matching an accepted same-cycle write SHALL return that write data (highest index winning); =0: returns stored value.
REQ-028 Read ports SHALL be independent; any port may address any thread.

Reset
REQ-029 rst_ni low SHALL force: FSM INIT, sweep counter 0, ready_o 0, clr_busy_o 0, clr_done_o 0, wr_conflict_o 0; array contents not reset (cleared by INIT).
REQ-030 Reset mid-CLEAR or mid-INIT SHALL abort and restart INIT from index 0.

Structure
REQ-031 FSM state enum and DATA/thread width defaults SHALL live in shared package mrv1_rf_pkg.
REQ-032 Write arbitration/conflict detection SHALL be one sub-module mrv1_rf_wr_arb; storage and FSM stay in top.

Verification
REQ-033 Reset release, defaults (ENTRIES_LP=256) -> ready_o high exactly 256 cycles later; every read returns 0.
REQ-034 Write t3/r5=0xDEADBEEF, next cycle read t3/r5 on port 2 -> 0xDEADBEEF; read t4/r5 -> 0; write t3/r0=0x1 -> read t3/r0 returns 0.
REQ-035 Both ports write t1/r7 (0x11 port0, 0x22 port1) -> stored 0x22, wr_conflict_o high one cycle only; bypass read same cycle -> 0x22.
REQ-036 t2 populated, clr_req_i with tid 2 -> clr_busy_o 32 cycles, clr_done_o one pulse, t2 regs read 0, t6 regs unchanged, write to t2 during clear dropped.
REQ-037 rst_ni asserted mid-CLEAR -> outputs to reset values immediately; ready_o returns after 256 cycles.
REQ-038 BYPASS_EN_P=0, write t0/r9=0x5 while reading t0/r9 -> old value same cycle, 0x5 next cycle.

Source files
------------

// File: rtl/mrv1_rf_pkg.sv
// Shared types and default widths for the multi-ported, multi-threaded register file.
package mrv1_rf_pkg;

    localparam int unsigned RF_DATA_WIDTH_DEF  = 32;
    localparam int unsigned RF_NUM_THREADS_DEF = 8;

    typedef enum logic [1:0] {
        RF_INIT,
        RF_IDLE,
        RF_CLEAR,
        RF_DONE
    } rf_state_e;

endpackage

// File: rtl/mrv1_rf_mp_if.sv
// Read/write/clear bundle of the register file; master drives requests, slave is the array.
interface mrv1_rf_mp_if
    import mrv1_rf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_P    = RF_DATA_WIDTH_DEF,
    parameter int unsigned NUM_THREADS_P   = RF_NUM_THREADS_DEF,
    parameter int unsigned RF_ADDR_WIDTH_P = 5,
    parameter int unsigned NUM_RD_PORTS_P  = 3,
    parameter int unsigned NUM_WR_PORTS_P  = 2
);

    localparam int unsigned TID_WIDTH_LP = $clog2(NUM_THREADS_P);

    logic [NUM_RD_PORTS_P-1:0][TID_WIDTH_LP-1:0]    rs_tid_i;
    logic [NUM_RD_PORTS_P-1:0][RF_ADDR_WIDTH_P-1:0] rs_addr_i;
    logic [NUM_RD_PORTS_P-1:0][DATA_WIDTH_P-1:0]    rs_data_o;

    logic [NUM_WR_PORTS_P-1:0]                      wr_en_i;
    logic [NUM_WR_PORTS_P-1:0][TID_WIDTH_LP-1:0]    wr_tid_i;
    logic [NUM_WR_PORTS_P-1:0][RF_ADDR_WIDTH_P-1:0] wr_addr_i;
    logic [NUM_WR_PORTS_P-1:0][DATA_WIDTH_P-1:0]    wr_data_i;

    logic                                           clr_req_i;
    logic [TID_WIDTH_LP-1:0]                        clr_tid_i;

    logic                                           ready_o;
    logic                                           clr_busy_o;
    logic                                           clr_done_o;
    logic                                           wr_conflict_o;

    modport master (
        output rs_tid_i, rs_addr_i,
        output wr_en_i, wr_tid_i, wr_addr_i, wr_data_i,
        output clr_req_i, clr_tid_i,
        input  rs_data_o, ready_o, clr_busy_o, clr_done_o, wr_conflict_o
    );

    modport slave (
        input  rs_tid_i, rs_addr_i,
        input  wr_en_i, wr_tid_i, wr_addr_i, wr_data_i,
        input  clr_req_i, clr_tid_i,
        output rs_data_o, ready_o, clr_busy_o, clr_done_o, wr_conflict_o
    );

endinterface

// File: rtl/mrv1_rf_wr_arb.sv
// Write-port arbitration: highest port index wins a shared entry; collisions flagged one cycle later.
module mrv1_rf_wr_arb #(
    parameter int unsigned NUM_WR_PORTS_P = 2,
    parameter int unsigned ENTRY_WIDTH_P  = 8
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic [NUM_WR_PORTS_P-1:0]                   wr_vld_i,
    input  logic [NUM_WR_PORTS_P-1:0][ENTRY_WIDTH_P-1:0] wr_entry_i,
    output logic [NUM_WR_PORTS_P-1:0]                   wr_win_o,
    output logic                                        wr_conflict_o
);

    logic conflict_d;

    // A valid port loses if any higher-indexed valid port targets the same entry.
    always_comb begin
        wr_win_o   = wr_vld_i;
        conflict_d = 1'b0;
        for (int unsigned i = 0; i < NUM_WR_PORTS_P; i++) begin
            for (int unsigned j = i + 1; j < NUM_WR_PORTS_P; j++) begin
                if (wr_vld_i[i] && wr_vld_i[j] && (wr_entry_i[i] == wr_entry_i[j])) begin
                    wr_win_o[i] = 1'b0;
                    conflict_d  = 1'b1;
                end
            end
        end
    end

    // Conflict flag covers exactly the cycle after the colliding writes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_conflict_o <= 1'b0;
        end else begin
            wr_conflict_o <= conflict_d;
        end
    end

endmodule

// File: rtl/mrv1_rf_mp.sv
// Multi-threaded, multi-ported register file with init sweep and per-thread clear.
module mrv1_rf_mp
    import mrv1_rf_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_P    = RF_DATA_WIDTH_DEF,
    parameter int unsigned NUM_THREADS_P   = RF_NUM_THREADS_DEF,
    parameter int unsigned RF_ADDR_WIDTH_P = 5,
    parameter int unsigned NUM_RD_PORTS_P  = 3,
    parameter int unsigned NUM_WR_PORTS_P  = 2,
    parameter int unsigned BYPASS_EN_P     = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    mrv1_rf_mp_if.slave bus
);

    localparam int unsigned TID_WIDTH_LP   = $clog2(NUM_THREADS_P);
    localparam int unsigned ENTRIES_LP     = NUM_THREADS_P << RF_ADDR_WIDTH_P;
    localparam int unsigned ENTRY_WIDTH_LP = TID_WIDTH_LP + RF_ADDR_WIDTH_P;

    logic [DATA_WIDTH_P-1:0] mem [ENTRIES_LP];

    rf_state_e                  state_q, state_d;
    logic [ENTRY_WIDTH_LP-1:0]  sweep_q, sweep_d;
    logic [TID_WIDTH_LP-1:0]    clr_tid_q, clr_tid_d;

    logic                       ready;
    logic                       clearing;
    logic                       sweep_we;
    logic [ENTRY_WIDTH_LP-1:0]  sweep_entry;

    logic [NUM_WR_PORTS_P-1:0]                     wr_vld;
    logic [NUM_WR_PORTS_P-1:0]                     wr_win;
    logic [NUM_WR_PORTS_P-1:0][ENTRY_WIDTH_LP-1:0] wr_entry;
    logic                                          wr_conflict;

    assign ready    = (state_q != RF_INIT);
    assign clearing = (state_q == RF_CLEAR);

    // INIT sweeps the whole array; CLEAR sweeps only the latched thread's slice.
    assign sweep_we    = (state_q == RF_INIT) || clearing;
    assign sweep_entry = clearing ? {clr_tid_q, sweep_q[RF_ADDR_WIDTH_P-1:0]} : sweep_q;

    // State, sweep index and clear target registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RF_INIT;
            sweep_q   <= '0;
            clr_tid_q <= '0;
        end else begin
            state_q   <= state_d;
            sweep_q   <= sweep_d;
            clr_tid_q <= clr_tid_d;
        end
    end

    // Next-state: INIT and CLEAR advance the sweep one entry per cycle.
    always_comb begin
        state_d   = state_q;
        sweep_d   = sweep_q;
        clr_tid_d = clr_tid_q;
        unique case (state_q)
            RF_INIT: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == ENTRY_WIDTH_LP'(ENTRIES_LP - 1)) begin
                    state_d = RF_IDLE;
                    sweep_d = '0;
                end
            end
            RF_IDLE: begin
                if (bus.clr_req_i) begin
                    state_d   = RF_CLEAR;
                    clr_tid_d = bus.clr_tid_i;
                    sweep_d   = '0;
                end
            end
            RF_CLEAR: begin
                sweep_d = sweep_q + 1'b1;
                if (&sweep_q[RF_ADDR_WIDTH_P-1:0]) begin
                    state_d = RF_DONE;
                    sweep_d = '0;
                end
            end
            RF_DONE: begin
                state_d = RF_IDLE;
            end
            default: begin
                state_d = RF_INIT;
                sweep_d = '0;
            end
        endcase
    end

    // Accept a write only when initialised, not to r0, and not into the thread being cleared.
    always_comb begin
        wr_vld   = '0;
        wr_entry = '0;
        for (int unsigned p = 0; p < NUM_WR_PORTS_P; p++) begin
            wr_entry[p] = {bus.wr_tid_i[p], bus.wr_addr_i[p]};
            wr_vld[p]   = ready && bus.wr_en_i[p] && (bus.wr_addr_i[p] != '0) &&
                          !(clearing && (bus.wr_tid_i[p] == clr_tid_q));
        end
    end

    mrv1_rf_wr_arb #(
        .NUM_WR_PORTS_P (NUM_WR_PORTS_P),
        .ENTRY_WIDTH_P  (ENTRY_WIDTH_LP)
    ) u_wr_arb (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .wr_vld_i      (wr_vld),
        .wr_entry_i    (wr_entry),
        .wr_win_o      (wr_win),
        .wr_conflict_o (wr_conflict)
    );

    // Array update; sweep and functional writes never share an entry since the cleared thread is blocked.
    always_ff @(posedge clk_i) begin
        for (int unsigned p = 0; p < NUM_WR_PORTS_P; p++) begin
            if (wr_win[p]) begin
                mem[wr_entry[p]] <= bus.wr_data_i[p];
            end
        end
        if (sweep_we) begin
            mem[sweep_entry] <= '0;
        end
    end

    // Combinational reads with r0/init/clear masking and optional same-cycle forwarding.
    always_comb begin
        bus.rs_data_o = '0;
        for (int unsigned r = 0; r < NUM_RD_PORTS_P; r++) begin
            if (ready && (bus.rs_addr_i[r] != '0) &&
                !(clearing && (bus.rs_tid_i[r] == clr_tid_q))) begin
                bus.rs_data_o[r] = mem[{bus.rs_tid_i[r], bus.rs_addr_i[r]}];
                if (BYPASS_EN_P != 0) begin
                    for (int unsigned w = 0; w < NUM_WR_PORTS_P; w++) begin
                        if (wr_win[w] && (wr_entry[w] == {bus.rs_tid_i[r], bus.rs_addr_i[r]})) begin
                            bus.rs_data_o[r] = bus.wr_data_i[w];
                        end
                    end
                end
            end
        end
    end

    assign bus.ready_o       = ready;
    assign bus.clr_busy_o    = clearing;
    assign bus.clr_done_o    = (state_q == RF_DONE);
    assign bus.wr_conflict_o = wr_conflict;

endmodule

// File: tb/tb_mrv1_rf_mp.sv
// Directed, table-driven bench for mrv1_rf_mp (bypassing and non-bypassing instances).
module tb_mrv1_rf_mp;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mrv1_rf_mp_if #(
        .DATA_WIDTH_P(32), .NUM_THREADS_P(8), .RF_ADDR_WIDTH_P(5),
        .NUM_RD_PORTS_P(3), .NUM_WR_PORTS_P(2)
    ) bus ();

    mrv1_rf_mp_if #(
        .DATA_WIDTH_P(32), .NUM_THREADS_P(8), .RF_ADDR_WIDTH_P(5),
        .NUM_RD_PORTS_P(3), .NUM_WR_PORTS_P(2)
    ) bus_nb ();

    mrv1_rf_mp #(
        .DATA_WIDTH_P(32), .NUM_THREADS_P(8), .RF_ADDR_WIDTH_P(5),
        .NUM_RD_PORTS_P(3), .NUM_WR_PORTS_P(2), .BYPASS_EN_P(1)
    ) u_dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    mrv1_rf_mp #(
        .DATA_WIDTH_P(32), .NUM_THREADS_P(8), .RF_ADDR_WIDTH_P(5),
        .NUM_RD_PORTS_P(3), .NUM_WR_PORTS_P(2), .BYPASS_EN_P(0)
    ) u_dut_nb (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_nb)
    );

    typedef struct {
        logic        we0;
        logic [2:0]  t0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        we1;
        logic [2:0]  t1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [2:0]  rt0;
        logic [4:0]  ra0;
        logic [31:0] exp0;
        logic [2:0]  rt2;
        logic [4:0]  ra2;
        logic [31:0] exp2;
        logic        exp_cf;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mkvec(
        input logic we0, input logic [2:0] t0, input logic [4:0] a0, input logic [31:0] d0,
        input logic we1, input logic [2:0] t1, input logic [4:0] a1, input logic [31:0] d1,
        input logic [2:0] rt0, input logic [4:0] ra0, input logic [31:0] exp0,
        input logic [2:0] rt2, input logic [4:0] ra2, input logic [31:0] exp2,
        input logic exp_cf);
        vec_t v;
        v.we0 = we0; v.t0 = t0; v.a0 = a0; v.d0 = d0;
        v.we1 = we1; v.t1 = t1; v.a1 = a1; v.d1 = d1;
        v.rt0 = rt0; v.ra0 = ra0; v.exp0 = exp0;
        v.rt2 = rt2; v.ra2 = ra2; v.exp2 = exp2;
        v.exp_cf = exp_cf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_all();
        bus.wr_en_i      = '0;  bus.wr_tid_i    = '0;  bus.wr_addr_i    = '0;  bus.wr_data_i    = '0;
        bus.rs_tid_i     = '0;  bus.rs_addr_i   = '0;  bus.clr_req_i    = 1'b0; bus.clr_tid_i   = '0;
        bus_nb.wr_en_i   = '0;  bus_nb.wr_tid_i = '0;  bus_nb.wr_addr_i = '0;  bus_nb.wr_data_i = '0;
        bus_nb.rs_tid_i  = '0;  bus_nb.rs_addr_i = '0; bus_nb.clr_req_i = 1'b0; bus_nb.clr_tid_i = '0;
    endtask

    task automatic wr(input int p, input logic [2:0] t, input logic [4:0] a, input logic [31:0] d);
        bus.wr_en_i[p]   = 1'b1;
        bus.wr_tid_i[p]  = t;
        bus.wr_addr_i[p] = a;
        bus.wr_data_i[p] = d;
    endtask

    task automatic rd(input int p, input logic [2:0] t, input logic [4:0] a);
        bus.rs_tid_i[p]  = t;
        bus.rs_addr_i[p] = a;
    endtask

    // Counts cycles from reset release to ready; pokes a write/read mid-INIT.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (bus.ready_o) begin
                n = i;
                break;
            end
            if (i == 100) begin
                wr(0, 3'd0, 5'd1, 32'hBAD0BAD0);
                rd(2, 3'd0, 5'd1);
                #1;
                chk({tag, " init read gated"}, bus.rs_data_o[2], 32'h0);
            end
            if (i == 101) idle_all();
        end
        chk({tag, " ready latency"}, n, 256);
        chk({tag, " nb ready"}, bus_nb.ready_o, 1);
        idle_all();
        rd(0, 3'd0, 5'd1);
        rd(2, 3'd7, 5'd31);
        #2;
        chk({tag, " init write dropped"}, bus.rs_data_o[0], 32'h0);
        chk({tag, " t7r31 zero"}, bus.rs_data_o[2], 32'h0);
    endtask

    int busy_cnt;

    initial begin
        vecs[0]  = mkvec(1,3,5,32'hDEADBEEF, 0,0,0,0,        4,5,32'h0,        3,5,32'hDEADBEEF, 0);
        vecs[1]  = mkvec(0,0,0,0,            0,0,0,0,        4,5,32'h0,        3,5,32'hDEADBEEF, 0);
        vecs[2]  = mkvec(1,3,0,32'h1,        0,0,0,0,        3,5,32'hDEADBEEF, 3,0,32'h0,        0);
        vecs[3]  = mkvec(0,0,0,0,            0,0,0,0,        0,0,32'h0,        3,0,32'h0,        0);
        vecs[4]  = mkvec(1,1,7,32'h11,       1,1,7,32'h22,   1,7,32'h22,       1,7,32'h22,       0);
        vecs[5]  = mkvec(0,0,0,0,            0,0,0,0,        1,7,32'h22,       1,7,32'h22,       1);
        vecs[6]  = mkvec(0,0,0,0,            0,0,0,0,        1,7,32'h22,       3,5,32'hDEADBEEF, 0);
        vecs[7]  = mkvec(1,2,4,32'h24,       1,6,3,32'h66,   2,4,32'h24,       6,3,32'h66,       0);
        vecs[8]  = mkvec(1,2,0,32'h55,       1,2,0,32'h77,   6,3,32'h66,       2,4,32'h24,       0);
        vecs[9]  = mkvec(0,0,0,0,            0,0,0,0,        2,0,32'h0,        2,4,32'h24,       0);
        vecs[10] = mkvec(1,5,31,32'hAAAA5555, 1,5,30,32'h1234, 5,30,32'h1234,  5,31,32'hAAAA5555, 0);
        vecs[11] = mkvec(0,0,0,0,            0,0,0,0,        5,30,32'h1234,    5,31,32'hAAAA5555, 0);

        idle_all();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rd(0, 3'd3, 5'd5);
        #1;
        chk("rst ready", bus.ready_o, 0);
        chk("rst busy", bus.clr_busy_o, 0);
        chk("rst done", bus.clr_done_o, 0);
        chk("rst conflict", bus.wr_conflict_o, 0);
        chk("rst read", bus.rs_data_o[0], 32'h0);
        idle_all();
        rst_n = 1'b1;
        wait_ready("init");

        // Non-bypassing instance: same-cycle read sees the old value.
        @(posedge clk); #1;
        idle_all();
        bus_nb.wr_en_i[0] = 1'b1; bus_nb.wr_tid_i[0] = 3'd0; bus_nb.wr_addr_i[0] = 5'd9; bus_nb.wr_data_i[0] = 32'h3;
        @(posedge clk); #1;
        bus_nb.wr_data_i[0] = 32'h5;
        bus_nb.rs_tid_i[2] = 3'd0; bus_nb.rs_addr_i[2] = 5'd9;
        #2;
        chk("nb same-cycle old", bus_nb.rs_data_o[2], 32'h3);
        @(posedge clk); #1;
        bus_nb.wr_en_i = '0;
        #2;
        chk("nb next-cycle new", bus_nb.rs_data_o[2], 32'h5);

        // Table-driven write/read/conflict vectors on the bypassing instance.
        @(posedge clk); #1;
        idle_all();
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            idle_all();
            bus.wr_en_i[0] = vecs[i].we0; bus.wr_tid_i[0] = vecs[i].t0; bus.wr_addr_i[0] = vecs[i].a0; bus.wr_data_i[0] = vecs[i].d0;
            bus.wr_en_i[1] = vecs[i].we1; bus.wr_tid_i[1] = vecs[i].t1; bus.wr_addr_i[1] = vecs[i].a1; bus.wr_data_i[1] = vecs[i].d1;
            rd(0, vecs[i].rt0, vecs[i].ra0);
            rd(1, vecs[i].rt2, vecs[i].ra2);
            rd(2, vecs[i].rt2, vecs[i].ra2);
            #3;
            chk($sformatf("vec%0d rd0", i), bus.rs_data_o[0], vecs[i].exp0);
            chk($sformatf("vec%0d rd1", i), bus.rs_data_o[1], vecs[i].exp2);
            chk($sformatf("vec%0d rd2", i), bus.rs_data_o[2], vecs[i].exp2);
            chk($sformatf("vec%0d conflict", i), bus.wr_conflict_o, vecs[i].exp_cf);
        end

        // Clear thread 2 while thread 6 keeps working.
        @(posedge clk); #1;
        idle_all();
        bus.clr_req_i = 1'b1;
        bus.clr_tid_i = 3'd2;
        #2;
        chk("clr busy before", bus.clr_busy_o, 0);
        @(posedge clk); #1;
        bus.clr_tid_i = 3'd6;
        wr(0, 3'd2, 5'd4, 32'h99);
        wr(1, 3'd6, 5'd8, 32'h68);
        rd(0, 3'd6, 5'd3);
        rd(2, 3'd2, 5'd4);
        #2;
        chk("clr busy first", bus.clr_busy_o, 1);
        chk("clr other thread read", bus.rs_data_o[0], 32'h66);
        chk("clr target read", bus.rs_data_o[2], 32'h0);
        busy_cnt = 1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (i == 0) idle_all();
            if (bus.clr_busy_o) busy_cnt++;
            else break;
        end
        chk("clr busy cycles", busy_cnt, 32);
        chk("clr done pulse", bus.clr_done_o, 1);
        @(posedge clk); #1;
        chk("clr done one cycle", bus.clr_done_o, 0);
        chk("clr busy after", bus.clr_busy_o, 0);
        rd(0, 3'd2, 5'd4);
        rd(1, 3'd6, 5'd8);
        rd(2, 3'd6, 5'd3);
        #2;
        chk("clr t2r4 zero", bus.rs_data_o[0], 32'h0);
        chk("clr t6r8 written", bus.rs_data_o[1], 32'h68);
        chk("clr t6r3 kept", bus.rs_data_o[2], 32'h66);
        @(posedge clk); #1;
        rd(0, 3'd5, 5'd31);
        rd(1, 3'd1, 5'd7);
        rd(2, 3'd2, 5'd31);
        #2;
        chk("post clr t5r31", bus.rs_data_o[0], 32'hAAAA5555);
        chk("post clr t1r7", bus.rs_data_o[1], 32'h22);
        chk("post clr t2r31", bus.rs_data_o[2], 32'h0);

        // Reset in the middle of a clear aborts it and restarts the init sweep.
        @(posedge clk); #1;
        idle_all();
        bus.clr_req_i = 1'b1;
        bus.clr_tid_i = 3'd5;
        @(posedge clk); #1;
        bus.clr_req_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        wr(0, 3'd1, 5'd9, 32'h1);
        wr(1, 3'd1, 5'd9, 32'h2);
        @(posedge clk); #1;
        idle_all();
        #1;
        chk("midclr conflict", bus.wr_conflict_o, 1);
        chk("midclr busy", bus.clr_busy_o, 1);
        rst_n = 1'b0;
        #1;
        chk("midclr rst ready", bus.ready_o, 0);
        chk("midclr rst busy", bus.clr_busy_o, 0);
        chk("midclr rst done", bus.clr_done_o, 0);
        chk("midclr rst conflict", bus.wr_conflict_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_ready("reinit");
        rd(0, 3'd5, 5'd31);
        rd(1, 3'd1, 5'd9);
        rd(2, 3'd1, 5'd7);
        #2;
        chk("reinit t5r31", bus.rs_data_o[0], 32'h0);
        chk("reinit t1r9", bus.rs_data_o[1], 32'h0);
        chk("reinit t1r7", bus.rs_data_o[2], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
